// File: rtl/risc_acc_pkg.sv
// Shared types for the risc_acc accumulator core: opcodes, FSM states and
// instruction field helpers. Instructions are {opcode[2:0], addr[ADDR_W-1:0]}.
package risc_acc_pkg;

    typedef enum logic [2:0] {
        OP_HLT = 3'd0,
        OP_SKZ = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_LDA = 3'd5,
        OP_STO = 3'd6,
        OP_JMP = 3'd7
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } state_e;

    // Callers pass the instruction zero-extended to 32 bits plus the address width.
    function automatic opcode_e instr_opcode(input logic [31:0] word, input int addr_w);
        return opcode_e'(3'(word >> addr_w));
    endfunction

    function automatic logic [31:0] instr_addr(input logic [31:0] word, input int addr_w);
        return word & ((32'd1 << addr_w) - 32'd1);
    endfunction

endpackage

// File: rtl/risc_acc_if.sv
// Program-load valid/ready handshake into the risc_acc core instruction memory.
interface risc_acc_if #(parameter int IW = 8);

    logic          load_valid;
    logic          load_ready;
    logic [IW-1:0] load_data;

    modport master (output load_valid, output load_data, input load_ready);
    modport slave  (input load_valid, input load_data, output load_ready);

endinterface

// File: rtl/risc_acc_alu.sv
// Combinational datapath of the risc_acc core; non-datapath opcodes pass acc through.
module risc_acc_alu
    import risc_acc_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] mem_out,
    input  opcode_e           opcode,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    logic [DATA_W:0] sum;

    always_comb begin
        sum    = {1'b0, acc} + {1'b0, mem_out};
        result = acc;
        case (opcode)
            OP_ADD:  result = sum[DATA_W-1:0];
            OP_AND:  result = acc & mem_out;
            OP_XOR:  result = acc ^ mem_out;
            OP_LDA:  result = mem_out;
            default: result = acc;
        endcase
    end

    assign carry = sum[DATA_W];

endmodule

// File: rtl/risc_acc_core.sv
// Multicycle accumulator CPU: loadable IMEM, DMEM, FETCH/DECODE/EXEC FSM.
// Optional single-step control is enabled by defining RISC_ACC_STEP_EN.
module risc_acc_core
    import risc_acc_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int ADDR_W = 5,
    localparam int IW     = 3 + ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    risc_acc_if.slave         load_if,
    input  logic              run,
`ifdef RISC_ACC_STEP_EN
    input  logic              step_mode,
    input  logic              step,
`endif
    output logic              halted,
    output logic              busy,
    output logic [IW-1:0]     instr,
    output logic [DATA_W-1:0] acc,
    output logic [DATA_W-1:0] mem_out,
    output logic [ADDR_W-1:0] pc,
    output logic              carry,
    output logic              zero
);

    localparam int DEPTH = 2 ** ADDR_W;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, load_ptr_q, load_ptr_d;
    logic [DATA_W-1:0] acc_q, acc_d, mem_out_q, mem_out_d;
    logic [IW-1:0]     instr_q, instr_d;
    logic              carry_q, carry_d;
    logic [IW-1:0]     imem_q [DEPTH];
    logic [DATA_W-1:0] dmem_q [DEPTH];
    logic              imem_we, dmem_we, fetch_go;
    opcode_e           cur_op;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;

    assign cur_op   = instr_opcode(32'(instr_q), ADDR_W);
    assign cur_addr = ADDR_W'(instr_addr(32'(instr_q), ADDR_W));

`ifdef RISC_ACC_STEP_EN
    assign fetch_go = !step_mode || step;
`else
    assign fetch_go = 1'b1;
`endif

    risc_acc_alu #(.DATA_W(DATA_W)) u_alu (
        .acc     (acc_q),
        .mem_out (mem_out_q),
        .opcode  (cur_op),
        .result  (alu_result),
        .carry   (alu_carry)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        acc_d      = acc_q;
        instr_d    = instr_q;
        mem_out_d  = mem_out_q;
        carry_d    = carry_q;
        load_ptr_d = load_ptr_q;
        imem_we    = 1'b0;
        dmem_we    = 1'b0;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (load_if.load_valid) begin
                    imem_we    = 1'b1;
                    load_ptr_d = load_ptr_q + ADDR_W'(1);
                end
                if (run) begin
                    pc_d       = '0;
                    acc_d      = '0;
                    carry_d    = 1'b0;
                    load_ptr_d = '0;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: begin
                if (fetch_go) begin
                    instr_d = imem_q[pc_q];
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                mem_out_d = dmem_q[cur_addr];
                state_d   = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                acc_d   = alu_result;
                case (cur_op)
                    OP_HLT:  state_d = S_HALT;
                    OP_SKZ:  if (acc_q == '0) pc_d = pc_q + ADDR_W'(1);
                    OP_ADD:  carry_d = alu_carry;
                    OP_STO:  dmem_we = 1'b1;
                    OP_JMP:  pc_d = cur_addr;
                    default: ;
                endcase
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            acc_q      <= '0;
            instr_q    <= '0;
            mem_out_q  <= '0;
            carry_q    <= 1'b0;
            load_ptr_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            acc_q      <= acc_d;
            instr_q    <= instr_d;
            mem_out_q  <= mem_out_d;
            carry_q    <= carry_d;
            load_ptr_q <= load_ptr_d;
        end
    end

    // Memories are not reset; gating writes on reset keeps an aborted STO from landing.
    always_ff @(posedge clock) begin
        if (imem_we && reset) imem_q[load_ptr_q] <= load_if.load_data;
        if (dmem_we && reset) dmem_q[cur_addr] <= acc_q;
    end

    assign load_if.load_ready = (state_q == S_IDLE) || (state_q == S_HALT);
    assign halted             = (state_q == S_HALT);
    assign busy               = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC);
    assign instr              = instr_q;
    assign acc                = acc_q;
    assign mem_out            = mem_out_q;
    assign pc                 = pc_q;
    assign carry              = carry_q;
    assign zero               = (acc_q == '0);

endmodule
